// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit: decodes LSU control codes, drives a req/gnt/rvalid
// data-memory port and returns extended load data for register writeback.
module jedro_1_lsu #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      ctrl_valid_i,
    input  logic [3:0]                ctrl_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
    output logic                      ready_o,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      misaligned_load_o,
    output logic                      misaligned_store_o,
    output logic                      illegal_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [3:0]                mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    localparam int unsigned BE_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REQ         = 2'd1,
        WAIT_RVALID = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                ctrl_q, ctrl_d;
    logic [1:0]                offs_q, offs_d;
    logic [REG_ADDR_WIDTH-1:0] regdest_q, regdest_d;

    logic                      ready_d;
    logic                      rf_we_d;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_d;
    logic [DATA_WIDTH-1:0]     rf_wdata_d;
    logic                      misaligned_load_d;
    logic                      misaligned_store_d;
    logic                      illegal_d;
    logic                      mem_req_d;
    logic                      mem_we_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_d;
    logic [BE_WIDTH-1:0]       mem_be_d;
    logic [DATA_WIDTH-1:0]     mem_wdata_d;

    logic                      legal;
    logic                      misaligned;
    logic [BE_WIDTH-1:0]       be_new;
    logic [DATA_WIDTH-1:0]     wdata_new;
    logic [DATA_WIDTH-1:0]     rdata_shift;
    logic [DATA_WIDTH-1:0]     load_data;

    // Decode the incoming command: legality, alignment, lanes and store data
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be_new     = '0;
        wdata_new  = '0;
        case (ctrl_i)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
            4'b1000, 4'b1001, 4'b1010: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
        case (ctrl_i[1:0])
            2'b00: begin
                be_new    = BE_WIDTH'(4'b0001 << addr_i[1:0]);
                wdata_new = DATA_WIDTH'({4{wdata_i[7:0]}});
            end
            2'b01: begin
                misaligned = addr_i[0];
                be_new     = BE_WIDTH'(4'b0011 << addr_i[1:0]);
                wdata_new  = DATA_WIDTH'({2{wdata_i[15:0]}});
            end
            default: begin
                misaligned = (addr_i[1:0] != 2'b00);
                be_new     = 4'b1111;
                wdata_new  = wdata_i;
            end
        endcase
    end

    // Extract and extend the addressed byte/half/word from read data
    always_comb begin
        rdata_shift = mem_rdata_i >> {offs_q, 3'b000};
        case (ctrl_q[1:0])
            2'b00: begin
                if (ctrl_q[2]) begin
                    load_data = {{(DATA_WIDTH-8){1'b0}}, rdata_shift[7:0]};
                end else begin
                    load_data = {{(DATA_WIDTH-8){rdata_shift[7]}}, rdata_shift[7:0]};
                end
            end
            2'b01: begin
                if (ctrl_q[2]) begin
                    load_data = {{(DATA_WIDTH-16){1'b0}}, rdata_shift[15:0]};
                end else begin
                    load_data = {{(DATA_WIDTH-16){rdata_shift[15]}}, rdata_shift[15:0]};
                end
            end
            default: load_data = rdata_shift;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d            = state_q;
        ctrl_d             = ctrl_q;
        offs_d             = offs_q;
        regdest_d          = regdest_q;
        rf_we_d            = 1'b0;
        rf_waddr_d         = rf_waddr_o;
        rf_wdata_d         = rf_wdata_o;
        misaligned_load_d  = 1'b0;
        misaligned_store_d = 1'b0;
        illegal_d          = 1'b0;
        mem_req_d          = mem_req_o;
        mem_we_d           = mem_we_o;
        mem_addr_d         = mem_addr_o;
        mem_be_d           = mem_be_o;
        mem_wdata_d        = mem_wdata_o;

        case (state_q)
            IDLE: begin
                if (ctrl_valid_i) begin
                    if (!legal) begin
                        illegal_d = 1'b1;
                    end else if (misaligned) begin
                        misaligned_store_d = ctrl_i[3];
                        misaligned_load_d  = ~ctrl_i[3];
                    end else begin
                        state_d     = REQ;
                        ctrl_d      = ctrl_i;
                        offs_d      = addr_i[1:0];
                        regdest_d   = regdest_i;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ctrl_i[3];
                        mem_addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_d    = be_new;
                        mem_wdata_d = ctrl_i[3] ? wdata_new : '0;
                    end
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d     = WAIT_RVALID;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                end
            end
            WAIT_RVALID: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    if (!ctrl_q[3]) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = regdest_q;
                        rf_wdata_d = load_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State, latched command and registered outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q            <= IDLE;
            ctrl_q             <= '0;
            offs_q             <= '0;
            regdest_q          <= '0;
            ready_o            <= 1'b1;
            rf_we_o            <= 1'b0;
            rf_waddr_o         <= '0;
            rf_wdata_o         <= '0;
            misaligned_load_o  <= 1'b0;
            misaligned_store_o <= 1'b0;
            illegal_o          <= 1'b0;
            mem_req_o          <= 1'b0;
            mem_we_o           <= 1'b0;
            mem_addr_o         <= '0;
            mem_be_o           <= '0;
            mem_wdata_o        <= '0;
        end else begin
            state_q            <= state_d;
            ctrl_q             <= ctrl_d;
            offs_q             <= offs_d;
            regdest_q          <= regdest_d;
            ready_o            <= ready_d;
            rf_we_o            <= rf_we_d;
            rf_waddr_o         <= rf_waddr_d;
            rf_wdata_o         <= rf_wdata_d;
            misaligned_load_o  <= misaligned_load_d;
            misaligned_store_o <= misaligned_store_d;
            illegal_o          <= illegal_d;
            mem_req_o          <= mem_req_d;
            mem_we_o           <= mem_we_d;
            mem_addr_o         <= mem_addr_d;
            mem_be_o           <= mem_be_d;
            mem_wdata_o        <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Bench for jedro_1_lsu: transaction model with expectation queues plus
// hand-computed literal checks on the directed vectors.
module tb_jedro_1_lsu;

    logic        clk_i;
    logic        rstn_i;
    logic        ctrl_valid_i;
    logic [3:0]  ctrl_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  regdest_i;
    logic        ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        misaligned_load_o;
    logic        misaligned_store_o;
    logic        illegal_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    jedro_1_lsu dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .ctrl_valid_i       (ctrl_valid_i),
        .ctrl_i             (ctrl_i),
        .addr_i             (addr_i),
        .wdata_i            (wdata_i),
        .regdest_i          (regdest_i),
        .ready_o            (ready_o),
        .rf_we_o            (rf_we_o),
        .rf_waddr_o         (rf_waddr_o),
        .rf_wdata_o         (rf_wdata_o),
        .misaligned_load_o  (misaligned_load_o),
        .misaligned_store_o (misaligned_store_o),
        .illegal_o          (illegal_o),
        .mem_req_o          (mem_req_o),
        .mem_we_o           (mem_we_o),
        .mem_addr_o         (mem_addr_o),
        .mem_be_o           (mem_be_o),
        .mem_wdata_o        (mem_wdata_o),
        .mem_gnt_i          (mem_gnt_i),
        .mem_rvalid_i       (mem_rvalid_i),
        .mem_rdata_i        (mem_rdata_i)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010, LBU = 4'b0100;
    localparam logic [3:0] LHU = 4'b0101, SB = 4'b1000, SH = 4'b1001, SW = 4'b1010;

    int checks   = 0;
    int failures = 0;
    int wb_seen  = 0;

    req_t        req_q[$];
    wb_t         wb_q[$];
    logic [2:0]  exc_q[$];
    logic [31:0] last_wb;

    logic        snap_we;
    logic [31:0] snap_addr;
    logic [3:0]  snap_be;
    logic [31:0] snap_wdata;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Access size in bytes
    function automatic int m_size(input logic [3:0] c);
        if (c[1:0] == 2'b00) return 1;
        if (c[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Exception kind {illegal, misaligned store, misaligned load}
    function automatic logic [2:0] m_exc(input logic [3:0] c, input logic [31:0] a);
        if (!(c inside {LB, LH, LW, LBU, LHU, SB, SH, SW})) return 3'b100;
        if ((int'(a[1:0]) % m_size(c)) != 0) return c[3] ? 3'b010 : 3'b001;
        return 3'b000;
    endfunction

    // Expected memory request for a legal aligned command
    function automatic req_t m_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd);
        req_t r;
        int   n;
        int   off;
        n       = m_size(c);
        off     = int'(a[1:0]);
        r.we    = c[3];
        r.addr  = {a[31:2], 2'b00};
        r.be    = '0;
        r.wdata = '0;
        for (int i = 0; i < n; i++) r.be[off + i] = 1'b1;
        if (c[3]) begin
            for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        return r;
    endfunction

    // Expected writeback value via integer arithmetic
    function automatic logic [31:0] m_load(input logic [3:0] c, input logic [31:0] a, input logic [31:0] rd);
        longint v;
        int     bits;
        bits = 8 * m_size(c);
        v    = longint'({32'd0, rd >> (8 * int'(a[1:0]))});
        v    = v % (longint'(1) << bits);
        if (!c[2] && bits < 32 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    // Per-cycle comparison against the expectation queues
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            req_q.delete();
            wb_q.delete();
            exc_q.delete();
            last_wb = 32'd0;
        end else begin
            chk("mem_req", 32'(mem_req_o), 32'(req_q.size() != 0));
            if (mem_req_o && req_q.size() != 0) begin
                chk("mem_we", 32'(mem_we_o), 32'(req_q[0].we));
                chk("mem_addr", mem_addr_o, req_q[0].addr);
                chk("mem_be", 32'(mem_be_o), 32'(req_q[0].be));
                chk("mem_wdata", mem_wdata_o, req_q[0].wdata);
                if (mem_gnt_i) void'(req_q.pop_front());
            end
            chk("exc_pulse", 32'(illegal_o | misaligned_store_o | misaligned_load_o), 32'(exc_q.size() != 0));
            if (exc_q.size() != 0) begin
                chk("exc_kind", 32'({illegal_o, misaligned_store_o, misaligned_load_o}), 32'(exc_q.pop_front()));
            end
            chk("rf_we", 32'(rf_we_o), 32'(wb_q.size() != 0));
            if (wb_q.size() != 0) begin
                wb_t e;
                e = wb_q.pop_front();
                chk("rf_waddr", 32'(rf_waddr_o), 32'(e.rd));
                chk("rf_wdata", rf_wdata_o, e.data);
                last_wb = e.data;
                wb_seen++;
            end else begin
                chk("rf_wdata_hold", rf_wdata_o, last_wb);
            end
        end
    end

    // Issue one command and serve its memory handshake
    task automatic do_cmd(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input int gdel, input int rvdel, input logic [31:0] rdata);
        int         n;
        logic [2:0] ek;
        wb_t        w;
        n = 0;
        while (ready_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ready_wait", 32'(ready_o), 32'd1);
        ctrl_valid_i = 1'b1;
        ctrl_i       = c;
        addr_i       = a;
        wdata_i      = wd;
        regdest_i    = rd;
        step();
        ctrl_valid_i = 1'b0;
        snap_we      = mem_we_o;
        snap_addr    = mem_addr_o;
        snap_be      = mem_be_o;
        snap_wdata   = mem_wdata_o;
        ek = m_exc(c, a);
        if (ek != 3'b000) begin
            exc_q.push_back(ek);
            return;
        end
        req_q.push_back(m_req(c, a, wd));
        repeat (gdel) step();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        repeat (rvdel) step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        step();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hA5A5_5A5A;
        if (!c[3]) begin
            w.rd   = rd;
            w.data = m_load(c, a, rdata);
            wb_q.push_back(w);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_we"}, 32'({mem_we_o, rf_we_o}), 32'd0);
        chk({tag, "_exc"}, 32'({illegal_o, misaligned_store_o, misaligned_load_o}), 32'd0);
        chk({tag, "_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_be_waddr"}, 32'({mem_be_o, rf_waddr_o}), 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o | rf_wdata_o, 32'd0);
    endtask

    initial begin
        int wb_base;
        rstn_i       = 1'b0;
        ctrl_valid_i = 1'b0;
        ctrl_i       = '0;
        addr_i       = '0;
        wdata_i      = '0;
        regdest_i    = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        last_wb      = '0;
        step();
        step();
        check_reset_outs("reset");
        rstn_i = 1'b1;
        step();

        // Word load, immediate grant, rvalid next cycle
        do_cmd(LW, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF);
        chk("lw_addr", snap_addr, 32'h100);
        chk("lw_be", 32'(snap_be), 32'hF);
        chk("lw_rf_we", 32'(rf_we_o), 32'd1);
        chk("lw_data", rf_wdata_o, 32'hDEADBEEF);
        chk("lw_waddr", 32'(rf_waddr_o), 32'd5);
        chk("lw_ready", 32'(ready_o), 32'd1);

        // Sub-word loads with sign/zero extension
        do_cmd(LB, 32'h103, 32'h0, 5'd6, 0, 1, 32'h80FF_0000);
        chk("lb_be", 32'(snap_be), 32'h8);
        chk("lb_data", rf_wdata_o, 32'hFFFFFF80);
        do_cmd(LBU, 32'h103, 32'h0, 5'd6, 1, 0, 32'h80FF_0000);
        chk("lbu_data", rf_wdata_o, 32'h00000080);
        do_cmd(LH, 32'h102, 32'h0, 5'd7, 0, 0, 32'h80FF_0000);
        chk("lh_be", 32'(snap_be), 32'hC);
        chk("lh_data", rf_wdata_o, 32'hFFFF80FF);
        do_cmd(LHU, 32'h102, 32'h0, 5'd7, 0, 2, 32'h80FF_0000);
        chk("lhu_data", rf_wdata_o, 32'h000080FF);
        do_cmd(LB, 32'h101, 32'h0, 5'd8, 0, 0, 32'h0000_7F00);
        chk("lb_pos", rf_wdata_o, 32'h0000007F);

        // Stores, including a delayed grant
        do_cmd(SB, 32'h201, 32'h12345678, 5'd9, 3, 1, 32'h0);
        chk("sb_we", 32'(snap_we), 32'd1);
        chk("sb_addr", snap_addr, 32'h200);
        chk("sb_be", 32'(snap_be), 32'h2);
        chk("sb_wdata", snap_wdata, 32'h78787878);
        chk("sb_no_wb", 32'(rf_we_o), 32'd0);
        do_cmd(SH, 32'h202, 32'hCAFEBABE, 5'd9, 1, 0, 32'h0);
        chk("sh_be", 32'(snap_be), 32'hC);
        chk("sh_wdata", snap_wdata, 32'hBABEBABE);
        do_cmd(SW, 32'h300, 32'h11223344, 5'd9, 0, 0, 32'h0);
        chk("sw_wdata", snap_wdata, 32'h11223344);

        // Misaligned and illegal commands
        do_cmd(SW, 32'h202, 32'h55, 5'd1, 0, 0, 32'h0);
        chk("sw_mis", 32'(misaligned_store_o), 32'd1);
        chk("sw_mis_noreq", 32'(mem_req_o), 32'd0);
        step();
        chk("sw_mis_once", 32'(misaligned_store_o), 32'd0);
        do_cmd(LH, 32'h301, 32'h0, 5'd1, 0, 0, 32'h0);
        chk("lh_mis", 32'(misaligned_load_o), 32'd1);
        step();
        chk("lh_mis_once", 32'(misaligned_load_o), 32'd0);
        do_cmd(4'b0011, 32'h400, 32'h0, 5'd1, 0, 0, 32'h0);
        chk("illegal", 32'(illegal_o), 32'd1);
        chk("illegal_noreq", 32'(mem_req_o), 32'd0);
        step();
        chk("illegal_once", 32'(illegal_o), 32'd0);
        do_cmd(4'b1100, 32'h400, 32'h0, 5'd1, 0, 0, 32'h0);
        chk("illegal_1100", 32'(illegal_o), 32'd1);
        do_cmd(LW, 32'h101, 32'h0, 5'd1, 0, 0, 32'h0);
        chk("lw_mis", 32'(misaligned_load_o), 32'd1);
        step();

        // Load to x0 is still written back
        do_cmd(LW, 32'h44, 32'h0, 5'd0, 0, 0, 32'h0BAD_F00D);
        chk("x0_we", 32'(rf_we_o), 32'd1);
        chk("x0_waddr", 32'(rf_waddr_o), 32'd0);

        // Reset while waiting for rvalid aborts the load
        ctrl_valid_i = 1'b1;
        ctrl_i       = LW;
        addr_i       = 32'h40;
        regdest_i    = 5'd7;
        step();
        ctrl_valid_i = 1'b0;
        req_q.push_back(m_req(LW, 32'h40, 32'h0));
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        chk("abort_busy", 32'(ready_o), 32'd0);
        rstn_i = 1'b0;
        #1;
        check_reset_outs("abort");
        step();
        rstn_i = 1'b1;
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12345678;
        step();
        mem_rvalid_i = 1'b0;
        chk("abort_no_wb", 32'(rf_we_o), 32'd0);
        chk("abort_ready", 32'(ready_o), 32'd1);

        // Spurious handshakes in IDLE, then back-to-back loads with valid held
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        step();
        step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        chk("spurious_no_wb", 32'(rf_we_o), 32'd0);
        wb_base      = wb_seen;
        ctrl_valid_i = 1'b1;
        ctrl_i       = LW;
        addr_i       = 32'h500;
        regdest_i    = 5'd10;
        step();
        req_q.push_back(m_req(LW, 32'h500, 32'h0));
        addr_i    = 32'h504;
        regdest_i = 5'd11;
        chk("b2b_busy", 32'(ready_o), 32'd0);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        chk("b2b_held_noreq", 32'(mem_req_o), 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_0001;
        step();
        mem_rvalid_i = 1'b0;
        wb_q.push_back('{rd: 5'd10, data: 32'h1111_0001});
        chk("b2b_ready", 32'(ready_o), 32'd1);
        step();
        ctrl_valid_i = 1'b0;
        req_q.push_back(m_req(LW, 32'h504, 32'h0));
        chk("b2b_second_req", mem_addr_o, 32'h504);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h2222_0002;
        step();
        mem_rvalid_i = 1'b0;
        wb_q.push_back('{rd: 5'd11, data: 32'h2222_0002});
        chk("b2b_waddr", 32'(rf_waddr_o), 32'd11);
        repeat (3) step();
        chk("b2b_count", 32'(wb_seen - wb_base), 32'd2);

        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
        chk("exc_q_empty", 32'(exc_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jedro_1_lsu.md
Name: jedro_1_lsu

Overview:
Load-store unit for the jedro_1 RV32I core. It consumes the 4-bit LSU control code produced by the decoder, together with the effective address and store data from the ALU/register file. It drives a req/gnt/rvalid data-memory port and returns sign- or zero-extended load data to register writeback. One transaction is in flight at a time. Misaligned accesses and illegal control codes are flagged without touching memory.

Parameters:
DATA_WIDTH, 32, data bus and register width
ADDR_WIDTH, 32, byte address width
REG_ADDR_WIDTH, 5, destination register index width

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
ctrl_valid_i  in  1  command valid from decode/execute
ctrl_i  in  4  LSU control code (encodings below)
addr_i  in  ADDR_WIDTH  effective byte address
wdata_i  in  DATA_WIDTH  store data, right-aligned
regdest_i  in  REG_ADDR_WIDTH  load destination register
ready_o  out  1  LSU can accept a command
rf_we_o  out  1  load writeback strobe, 1-cycle pulse
rf_waddr_o  out  REG_ADDR_WIDTH  writeback register index
rf_wdata_o  out  DATA_WIDTH  extended load data
misaligned_load_o  out  1  1-cycle pulse
misaligned_store_o  out  1  1-cycle pulse
illegal_o  out  1  1-cycle pulse for an unsupported ctrl code
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = store
mem_addr_o  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
mem_be_o  out  4  byte enables
mem_wdata_o  out  DATA_WIDTH  lane-aligned store data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  response valid
mem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- Control code encodings:
  - 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU.
  - 1000 SB, 1001 SH, 1010 SW.
  - Any other code is illegal.
- Reset: all outputs are 0 except ready_o. State = IDLE. Internal registers are cleared. Assertion mid-transaction aborts immediately: mem_req_o drops and no writeback occurs.
- Registered outputs: all mem_* outputs are registered and hold their value from the cycle after acceptance until grant.
- FSM states: IDLE, REQ, WAIT_RVALID. ready_o = (state == IDLE).
- IDLE: accept when ctrl_valid_i && ready_o.
  - Illegal code: pulse illegal_o next cycle; no request; stay in IDLE.
  - LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0: pulse misaligned_load_o or misaligned_store_o next cycle; no request; stay in IDLE.
  - Otherwise latch ctrl, addr, wdata and regdest. Go to REQ with mem_req_o = 1 in the following cycle.
- REQ: hold mem_req_o and all mem_* outputs stable until mem_gnt_i. In the grant cycle move to WAIT_RVALID; mem_req_o is 0 from the next cycle.
- WAIT_RVALID: wait for mem_rvalid_i.
  - Load: pulse rf_we_o next cycle with rf_waddr_o = latched regdest and rf_wdata_o = extracted data.
  - Store: completes with no writeback.
  - Both return to IDLE in the same cycle that rf_we_o is asserted.
- Minimum command-to-writeback latency is 3 cycles: accept → req (gnt same cycle) → rvalid → rf_we_o.
- Byte enables by access size:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << addr[1:0].
  - Word: 1111.
- Store lane alignment: mem_wdata_o = wdata shifted left by 8*addr[1:0], with the byte or half replicated into its lane. Loads drive mem_wdata_o = 0 and mem_we_o = 0.
- Load extraction: shift mem_rdata_i right by 8*addr[1:0], then:
  - LB/LH: sign-extend bit 7 or bit 15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Spurious handshakes: mem_gnt_i outside REQ and mem_rvalid_i outside WAIT_RVALID are ignored. A command presented while ready_o = 0 is not accepted; the upstream stage holds it.
- rf_wdata_o holds its last value when rf_we_o = 0. rf_we_o is never asserted for stores, misaligned accesses or illegal codes.
- x0 destination: writeback to rf_waddr_o = 0 is still pulsed; the register file discards it.

Test Plan:
- LW at 0x100, gnt immediate, rvalid 1 cycle later with rdata 0xDEADBEEF → mem_addr_o = 0x100, be = 1111, rf_we_o pulses with 0xDEADBEEF to regdest 5; ready_o returns to 1.
- LB at 0x103 with rdata 0x80FF_0000 → be = 1000, rf_wdata_o = 0xFFFFFF80. LBU on the same data → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB wdata 0x12345678 at 0x201 → mem_we_o = 1, addr 0x200, be = 0010, mem_wdata_o = 0x78787878 (the 0x78 byte replicated into all four lanes); gnt delayed 3 cycles with outputs stable throughout; no rf_we_o.
- SW at 0x202 → misaligned_store_o pulses once, mem_req_o stays 0. LH at 0x301 → misaligned_load_o pulses once. ctrl 0011 → illegal_o pulses once, no request.
- rstn_i asserted while in WAIT_RVALID, then an rvalid arrives after release → all outputs 0, ready_o = 1, no rf_we_o pulse.
- Spurious gnt/rvalid in IDLE, then two back-to-back LW with ctrl_valid_i held → second accepted only when ready_o = 1; exactly two writebacks, in order.
